uart_tx_fifo: RTL

Parametrised UART transmitter with a built-in transmit FIFO. It is the next generation of the team's UART TX path. Data width, FIFO depth and system clock frequency are parameters. Stop-bit count is selectable at run time, and back-to-back frames are queued without waiting for the host. It sits between the host write interface and the serial line, upstream of the existing UART receiver in the duplex top level.

---
 rtl/uart_tx_fifo_if.sv | 32 +++
 rtl/uart_tx_fifo.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-side write port and serial/status outputs of the UART transmitter.
// The host (master) pushes words and picks the frame format; the
// transmitter (slave) drives the line and reports FIFO/frame status.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                              wr_en;
  logic [DATA_WIDTH-1:0]             data_in;
  logic [1:0]                        parity_type;
  logic [1:0]                        baud_rate;
  logic                              stop_bits;
  logic                              tx_out;
  logic                              tx_active_flag;
  logic                              tx_done_flag;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count;
  logic                              overflow_flag;

  modport master (
    output wr_en, data_in, parity_type, baud_rate, stop_bits,
    input  tx_out, tx_active_flag, tx_done_flag,
    input  fifo_full, fifo_empty, fifo_count, overflow_flag
  );

  modport slave (
    input  wr_en, data_in, parity_type, baud_rate, stop_bits,
    output tx_out, tx_active_flag, tx_done_flag,
    output fifo_full, fifo_empty, fifo_count, overflow_flag
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO. Frame format (parity, baud rate,
// stop bits) is captured when a word is popped, so host-side changes only
// affect frames that have not started yet.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high; pops the FIFO head and captures format if not empty
// S_START  | start bit (line low) for one bit period
// S_DATA   | DATA_WIDTH payload bits, LSB first
// S_PARITY | parity bit (only when parity enabled)
// S_STOP   | one or two stop bits; done pulse in the very last cycle
module uart_tx_fifo #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int DIV_2400  = CLOCK_FREQ / 2400;
  localparam int DIV_4800  = CLOCK_FREQ / 4800;
  localparam int DIV_9600  = CLOCK_FREQ / 9600;
  localparam int DIV_19200 = CLOCK_FREQ / 19200;
  // Bit timer holds DIV-1 down to 0, so the slowest rate sets its width.
  localparam int TW = $clog2(DIV_2400 + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Terminal count for the selected rate (timer counts DIV-1 .. 0).
  function automatic logic [TW-1:0] div_sel(input logic [1:0] rate);
    logic [TW-1:0] tc;
    case (rate)
      2'b00:   tc = TW'(DIV_2400 - 1);
      2'b01:   tc = TW'(DIV_4800 - 1);
      2'b10:   tc = TW'(DIV_9600 - 1);
      default: tc = TW'(DIV_19200 - 1);
    endcase
    return tc;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [TW-1:0]         div_q, div_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  par_q, par_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  stop_idx_q, stop_idx_d;

  logic                  full, empty, push, pop, tc, tx_bit, done;
  logic [DATA_WIDTH-1:0] head;

  // Full is judged on the registered count, so a same-cycle pop never admits a write.
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.wr_en && !full;
  assign head  = mem_q[rd_ptr_q];
  assign tc    = (timer_q == '0);

  // FIFO bookkeeping: pointers wrap naturally, count tells full from empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (bus.wr_en && full) ovf_d = 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer: next state, bit timer and line value.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    div_d      = div_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    pop        = 1'b0;
    tx_bit     = 1'b1;
    done       = 1'b0;

    if (state_q != S_IDLE) timer_d = tc ? div_q : timer_q - TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_d    = head;
          par_en_d   = (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
          par_d      = (^head) ^ (bus.parity_type == 2'b01);
          stop2_d    = bus.stop_bits;
          div_d      = div_sel(bus.baud_rate);
          timer_d    = div_sel(bus.baud_rate);
          idx_d      = '0;
          stop_idx_d = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        tx_bit = 1'b0;
        if (tc) state_d = S_DATA;
      end
      S_DATA: begin
        tx_bit = shift_q[0];
        if (tc) begin
          shift_d = shift_q >> 1;
          if (idx_q == IW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        tx_bit = par_q;
        if (tc) state_d = S_STOP;
      end
      S_STOP: begin
        tx_bit = 1'b1;
        if (tc) begin
          if (stop_idx_q == stop2_q) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and control registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care after reset since the count is cleared.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.tx_out         = tx_bit;
  assign bus.tx_active_flag = (state_q != S_IDLE);
  assign bus.tx_done_flag   = done;
  assign bus.fifo_full      = full;
  assign bus.fifo_empty     = empty;
  assign bus.fifo_count     = count_q;
  assign bus.overflow_flag  = ovf_q;

endmodule
